cp0_unit: RTL and testbench

Coprocessor-0 inside the CPU, sitting at the M stage. It consumes the 6-bit hardware interrupt vector built at the top level as {3'b0, interrupt, TC1_IRQ, TC0_IRQ} and the exception code carried down the pipeline. It holds SR, Cause, EPC and PRId, and raises a single-cycle-decided request that flushes the pipeline and redirects fetch to the handler. It services mtc0, mfc0 and eret.

---
 rtl/cp0_pkg.sv | 29 ++
 rtl/cp0_unit.sv | 111 +++++++++++
 tb/tb_cp0_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes and SR/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // SR fields
    localparam int SR_IM_HI = 15;
    localparam int SR_IM_LO = 10;
    localparam int SR_EXL   = 1;
    localparam int SR_IE    = 0;

    // Cause fields
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor-0 at the M stage: SR/Cause/EPC/PRId, exception/interrupt request, mtc0/mfc0/eret.
// Optional build macro CP0_PRID_EN makes register 15 read PRID_VALUE (otherwise it reads 0).
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h2023_0007,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

`ifdef CP0_PRID_EN
    localparam logic PRID_EN = 1'b1;
`else
    localparam logic PRID_EN = 1'b0;
`endif

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] epc_next;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req  = (|(hw_int & im)) & ie & ~exl;
    assign exc_req  = (exc_code_in != EXC_INT) & ~exl;
    assign req      = int_req | exc_req;

    // A delay-slot instruction restarts at its branch, one word earlier.
    assign epc_next = (bd_in ? (vpc - 32'd4) : vpc) & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= hw_int;
            if (req) begin
                exl      <= 1'b1;
                bd       <= bd_in;
                exc_code <= int_req ? EXC_INT : exc_code_in;
                epc      <= epc_next;
            end else begin
                if (we && cp0_addr == CP0_SR) begin
                    im  <= cp0_wdata[SR_IM_HI:SR_IM_LO];
                    exl <= cp0_wdata[SR_EXL];
                    ie  <= cp0_wdata[SR_IE];
                end
                if (we && cp0_addr == CP0_EPC) begin
                    epc <= {cp0_wdata[31:2], 2'b00};
                end
                // Placed after the SR write so eret's EXL clear takes precedence.
                if (eret) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        sr_word = '0;
        sr_word[SR_IM_HI:SR_IM_LO] = im;
        sr_word[SR_EXL]            = exl;
        sr_word[SR_IE]             = ie;

        cause_word = '0;
        cause_word[CAUSE_BD]                   = bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]    = ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exc_code;
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR:    cp0_rdata = sr_word;
            CP0_CAUSE: cp0_rdata = cause_word;
            CP0_EPC:   cp0_rdata = epc;
            CP0_PRID:  cp0_rdata = PRID_EN ? PRID_VALUE : 32'h0;
            default:   cp0_rdata = '0;
        endcase
    end

    assign epc_out    = epc;
    assign handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: expected values queued with stimulus, popped against DUT outputs.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    logic [31:0] exp_q[$];
    int          n_compared;
    int          n_mismatched;

    cp0_unit dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .cp0_rdata  (cp0_rdata),
        .vpc        (vpc),
        .bd_in      (bd_in),
        .exc_code_in(exc_code_in),
        .hw_int     (hw_int),
        .eret       (eret),
        .req        (req),
        .epc_out    (epc_out),
        .handler_pc (handler_pc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] exp);
        exp_q.push_back(exp);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL %s: got %08h expected <empty queue>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    // drivers
    task automatic read_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cp0_addr = addr;
        push_exp(exp);
        #1;
        pop_check(tag, cp0_rdata);
    endtask

    task automatic expect_req(input string tag, input logic exp);
        push_exp({31'b0, exp});
        #1;
        pop_check(tag, {31'b0, req});
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        we        = 1'b1;
        cp0_addr  = addr;
        cp0_wdata = data;
        tick();
        we        = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd;
        n_compared   = 0;
        n_mismatched = 0;
        reset = 1'b1;  we = 1'b0;  cp0_addr = '0;  cp0_wdata = '0;
        vpc = '0;  bd_in = 1'b0;  exc_code_in = '0;  hw_int = '0;  eret = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        hw_int = 6'b000100;
        read_reg("rst_sr", 5'd12, 32'h0);
        read_reg("rst_cause", 5'd13, 32'h0);
        read_reg("rst_epc", 5'd14, 32'h0);
        expect_req("rst_req", 1'b0);
        check("rst_epc_out", epc_out, 32'h0);
        check("handler_pc", handler_pc, 32'h0000_4180);
`ifdef CP0_PRID_EN
        read_reg("prid", 5'd15, 32'h2023_0007);
`else
        read_reg("prid", 5'd15, 32'h0);
`endif

        // interrupt taken
        hw_int = '0;
        mtc0(5'd12, 32'h0000_0401);
        read_reg("sr_wr", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001;  vpc = 32'h0000_3010;  bd_in = 1'b0;
        expect_req("int_req", 1'b1);
        tick();
        read_reg("int_sr", 5'd12, 32'h0000_0403);
        read_reg("int_cause", 5'd13, 32'h0000_0400);
        read_reg("int_epc", 5'd14, 32'h0000_3010);
        expect_req("int_exl_mask", 1'b0);

        // overflow exception in delay slot
        hw_int = '0;
        mtc0(5'd12, 32'h0);
        exc_code_in = 5'd12;  vpc = 32'h0000_3024;  bd_in = 1'b1;
        expect_req("ov_req", 1'b1);
        tick();
        exc_code_in = '0;  bd_in = 1'b0;
        read_reg("ov_epc", 5'd14, 32'h0000_3020);
        read_reg("ov_cause", 5'd13, 32'h8000_0030);

        // interrupt outranks exception
        mtc0(5'd12, 32'h0000_1001);
        hw_int = 6'b000100;  exc_code_in = 5'd10;  vpc = 32'h0000_3100;
        expect_req("prio_req", 1'b1);
        tick();
        exc_code_in = '0;
        read_reg("prio_cause", 5'd13, 32'h0000_1000);
        read_reg("prio_epc", 5'd14, 32'h0000_3100);

        // EXL masks everything; eret reopens the pending interrupt
        exc_code_in = 5'd4;
        expect_req("exl_mask", 1'b0);
        exc_code_in = '0;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        read_reg("eret_sr", 5'd12, 32'h0000_1001);
        expect_req("eret_reint", 1'b1);

        // mtc0 EPC suppressed by req, then effective
        vpc = 32'h0000_3200;
        mtc0(5'd14, 32'h0000_3047);
        read_reg("epc_suppr", 5'd14, 32'h0000_3200);
        hw_int = '0;
        mtc0(5'd14, 32'h0000_3047);
        read_reg("epc_wr", 5'd14, 32'h0000_3044);
        check("epc_out", epc_out, 32'h0000_3044);

        // eret together with SR write: EXL clear wins
        eret = 1'b1;
        mtc0(5'd12, 32'h0000_0403);
        eret = 1'b0;
        read_reg("eret_sr_wr", 5'd12, 32'h0000_0401);

        // ignored writes and unimplemented reads
        mtc0(5'd13, 32'hFFFF_FFFF);
        read_reg("cause_ro", 5'd13, 32'h0);
        read_reg("unimpl", 5'd3, 32'h0);

        // random EPC writes with no request pending
        for (int i = 0; i < 4; i++) begin
            rnd = $urandom;
            mtc0(5'd14, rnd);
            read_reg("epc_rnd", 5'd14, {rnd[31:2], 2'b00});
        end

        // reset clears a live EXL
        reset = 1'b1;
        tick();
        reset = 1'b0;
        read_reg("rst2_sr", 5'd12, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
